// File: rtl/bus_decoder.sv
// Address decoder and access sequencer: latches one request, decodes it to a
// region, drives that region's chip select for its wait time, then completes.
module bus_decoder #(
  parameter int unsigned                N_REGION     = 5,
  parameter int unsigned                ADDR_W       = 32,
  parameter int unsigned                DATA_W       = 32,
  parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE  = {ADDR_W'(0), ADDR_W'(3), ADDR_W'(2),
                                                        ADDR_W'(1), ADDR_W'(0)},
  parameter logic [N_REGION*ADDR_W-1:0] REGION_LIMIT = {ADDR_W'(0), ADDR_W'(8), ADDR_W'(2),
                                                        ADDR_W'(1), ADDR_W'(0)},
  parameter logic [N_REGION*4-1:0]      REGION_WAIT  = {4'd2, 4'd1, 4'd0, 4'd0, 4'd0},
  parameter int unsigned                DEFAULT_EN   = 1,
  parameter int unsigned                DEFAULT_IDX  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       we,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       busy,
  output logic                       ready,
  output logic                       err,
  output logic [DATA_W-1:0]          rdata,
  output logic [N_REGION-1:0]        cs,
  output logic [ADDR_W-1:0]          p_addr,
  output logic                       p_we,
  output logic [DATA_W-1:0]          p_wdata,
  input  logic [N_REGION*DATA_W-1:0] p_rdata
);

  localparam int unsigned SEL_W = (N_REGION > 1) ? $clog2(N_REGION) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERROR} state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [3:0]          r_cnt;
  logic                r_busy;
  logic                r_ready;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [N_REGION-1:0] r_cs;
  logic [ADDR_W-1:0]   r_p_addr;
  logic                r_p_we;
  logic [DATA_W-1:0]   r_p_wdata;

  logic                w_hit;
  logic                w_go;
  logic [SEL_W-1:0]    w_sel;
  logic [3:0]          w_wait;
  logic [DATA_W-1:0]   w_rd_slice;

  // Lowest matching region wins; the default region only applies when nothing matched.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int unsigned i = 0; i < N_REGION; i++) begin
      if (!w_hit && (addr >= REGION_BASE[i*ADDR_W +: ADDR_W])
                 && (addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
    w_go = w_hit;
    if (!w_hit && (DEFAULT_EN != 0)) begin
      w_go  = 1'b1;
      w_sel = SEL_W'(DEFAULT_IDX);
    end
    w_wait = REGION_WAIT[w_sel*4 +: 4];
  end

  assign w_rd_slice = p_rdata[r_sel*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_cs      <= '0;
      r_p_addr  <= '0;
      r_p_we    <= 1'b0;
      r_p_wdata <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_p_addr  <= addr;
            r_p_we    <= we;
            r_p_wdata <= wdata;
            r_busy    <= 1'b1;
            if (w_go) begin
              r_state <= S_ACCESS;
              r_sel   <= w_sel;
              r_cnt   <= w_wait;
              r_cs    <= {{(N_REGION-1){1'b0}}, 1'b1} << w_sel;
            end else begin
              r_state <= S_ERROR;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_cs    <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_cs    <= '0;
            r_ready <= 1'b1;
            if (!r_p_we) r_rdata <= w_rd_slice;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERROR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cs    <= '0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign ready   = r_ready;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign cs      = r_cs;
  assign p_addr  = r_p_addr;
  assign p_we    = r_p_we;
  assign p_wdata = r_p_wdata;

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 The block SHALL have parameter N_REGION, default 5, giving the number of decoded regions and chip selects.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-004 The block SHALL have parameter REGION_BASE, N_REGION*ADDR_W bits, default {0,1,2,3,0} (region 0 in the LSBs), giving each region's inclusive lower address.
REQ-005 The block SHALL have parameter REGION_LIMIT, N_REGION*ADDR_W bits, default {0,1,2,8,0}, giving each region's inclusive upper address.
REQ-006 The block SHALL have parameter REGION_WAIT, N_REGION*4 bits, default {0,0,0,1,2}, giving the extra wait cycles per region (0..15).
REQ-007 The block SHALL have parameter DEFAULT_EN, default 1; when 1, a non-matching address SHALL select region DEFAULT_IDX.
REQ-008 The block SHALL have parameter DEFAULT_IDX, default 4 (RAM).
REQ-009 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-010 Port: rst  in  1  synchronous, active-high reset.
REQ-011 Port: req  in  1  access request, sampled only in IDLE.
REQ-012 Port: addr  in  ADDR_W  access address.
REQ-013 Port: we  in  1  1 = write, 0 = read.
REQ-014 Port: wdata  in  DATA_W  write data.
REQ-015 Port: busy  out  1  high in every state except IDLE.
REQ-016 Port: ready  out  1  one-cycle completion pulse.
REQ-017 Port: err  out  1  one-cycle pulse, coincident with ready, for an unmapped access.
REQ-018 Port: rdata  out  DATA_W  read data, valid while ready is high and held until the next completion.
REQ-019 Port: cs  out  N_REGION  one-hot chip select.
REQ-020 Port: p_addr, p_we, p_wdata  out  ADDR_W/1/DATA_W  latched access, driven to the peripherals.
REQ-021 Port: p_rdata  in  N_REGION*DATA_W  per-region read data, region 0 in the LSBs.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS, DONE and ERROR.
REQ-023 In IDLE with req=1 the block SHALL latch addr, we and wdata into p_addr, p_we and p_wdata, and SHALL hold them until it returns to IDLE.
REQ-024 Decode SHALL select region i when REGION_BASE[i] <= addr <= REGION_LIMIT[i], using unsigned compares.
REQ-025 When regions overlap, the lowest matching index SHALL win.
REQ-026 A non-matching address SHALL select DEFAULT_IDX if DEFAULT_EN=1; otherwise it SHALL go to ERROR.
REQ-027 On a match (or default) the FSM SHALL go IDLE->ACCESS and load the wait counter with REGION_WAIT[sel].
REQ-028 In ACCESS the block SHALL hold cs[sel]=1 and all other cs bits 0, decrementing the counter each cycle.
REQ-029 ACCESS SHALL last REGION_WAIT[sel]+1 cycles.
REQ-030 On the last ACCESS cycle, for a read, the block SHALL capture p_rdata[sel] into rdata; for a write, rdata SHALL be unchanged.
REQ-031 The block SHALL then go ACCESS->DONE.
REQ-032 DONE SHALL last one cycle, with ready=1, cs=0 and err=0, and SHALL then return to IDLE.
REQ-033 ERROR SHALL last one cycle, with ready=1, err=1, cs=0 and rdata=0, and SHALL then return to IDLE.
REQ-034 Latency: for a req sampled at edge k, cs SHALL be high for cycles k+1..k+1+W and ready SHALL be high in cycle k+2+W, where W=REGION_WAIT[sel].
REQ-035 Unmapped latency: ready and err SHALL be high in cycle k+1.
REQ-036 A req outside IDLE SHALL be ignored and SHALL NOT be queued; the master re-asserts req after ready.
REQ-037 Minimum request spacing SHALL be W+3 cycles.
REQ-038 cs SHALL never have more than one bit set, and SHALL be all zero outside ACCESS.
REQ-039 Address changes after the request is latched SHALL have no effect on the access in progress.
REQ-040 Address boundaries SHALL be exact: BASE-1 and LIMIT+1 SHALL NOT select the region.

Reset
REQ-041 With rst=1 at a clock edge, the next state SHALL be IDLE.
REQ-042 Reset SHALL clear cs, ready, err, busy, rdata, p_addr, p_we, p_wdata and the wait counter to 0.
REQ-043 Reset asserted mid-ACCESS SHALL drop cs in the following cycle and SHALL produce no ready pulse.
REQ-044 rst SHALL take priority over req in the same cycle.

Verification
REQ-045 Read of addr=0, p_rdata[0]=0xA5 -> cs=00001 for 1 cycle, then ready=1 with rdata=0xA5.
REQ-046 Write of addr=5 -> cs=01000 for 2 cycles with p_we=1, then ready; rdata unchanged.
REQ-047 Reads of addr=8 and addr=9 -> 8 asserts cs[3]; 9 asserts cs[4] for 3 cycles; with DEFAULT_EN=0, 9 gives ready=err=1 at k+1 and cs never set.
REQ-048 req held high continuously -> exactly one access per IDLE visit, spacing W+3 cycles, never two cs bits set.
REQ-049 rst during the 2nd ACCESS cycle of an addr=100 read -> cs=0 next cycle, no ready, busy=0; next req serviced normally.
REQ-050 Overlap config with region 1 = [0,15] and region 3 = [3,8], addr=4 -> cs[1] selected.
